seq_frame_transmitter: RTL and testbench

Serial frame transmitter for the 4-bit sequence-detector link: accepts 4-bit words over a valid/ready handshake and drives them MSB-first on a single serial line in fixed, back-to-back 4-cycle frame slots aligned to reset. When no word is pending, a filler frame is sent so slot alignment with the downstream detector is never lost. The block also produces a golden "expected detect" strobe for the detectable patterns 0111, 1001 and 1110, for self-checking benches.

---
 rtl/seq_frame_transmitter.sv | 103 ++++++++++
 tb/tb_seq_frame_transmitter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_frame_transmitter                                                    |
// | 4-bit word -> MSB-first serial frames in fixed 4-cycle slots, with       |
// | filler frames and an optional expected-detect strobe                     |
// | (SEQ_TX_EXPECT_EN).                                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_frame_transmitter #(
   parameter logic [3:0] FILLER = 4'b0000,
   parameter int         CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   output logic             in_ready,
   output logic             out,
   output logic             frame_start,
   output logic             exp_dec,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam logic [1:0] C_LAST_SLOT = 2'd3;

   logic [1:0]       r_slot;
   logic [3:0]       r_sreg;
   logic [3:0]       r_buf;
   logic             r_buf_full;
   logic [CNT_W-1:0] r_frame_cnt;

   logic             w_boundary;
   logic             w_accept;
   logic             w_load_user;
   logic [3:0]       w_next_frame;

   assign w_boundary = (r_slot == C_LAST_SLOT);
   assign w_accept   = in_valid && !r_buf_full;

   // Buffered word wins; otherwise a word offered on the boundary bypasses the buffer.
   always_comb begin
      w_load_user  = 1'b1;
      w_next_frame = r_buf;
      if (!r_buf_full) begin
         if (w_accept) begin
            w_next_frame = in_data;
         end else begin
            w_load_user  = 1'b0;
            w_next_frame = FILLER;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot      <= 2'd0;
         r_sreg      <= FILLER;
         r_buf       <= FILLER;
         r_buf_full  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_slot <= r_slot + 2'd1;
         if (w_boundary) begin
            r_sreg     <= w_next_frame;
            r_buf_full <= 1'b0;
            if (w_load_user) begin
               r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
         end else begin
            r_sreg <= {r_sreg[2:0], 1'b0};
            if (w_accept) begin
               r_buf      <= in_data;
               r_buf_full <= 1'b1;
            end
         end
      end
   end

`ifdef SEQ_TX_EXPECT_EN
   logic [3:0] r_frame_latch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_latch <= FILLER;
      end else if (w_boundary) begin
         r_frame_latch <= w_next_frame;
      end
   end

   assign exp_dec = w_boundary && ((r_frame_latch == 4'b0111) ||
                                   (r_frame_latch == 4'b1001) ||
                                   (r_frame_latch == 4'b1110));
`else
   assign exp_dec = 1'b0;
`endif

   assign out         = r_sreg[3];
   assign frame_start = (r_slot == 2'd0);
   assign in_ready    = !r_buf_full;
   assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_transmitter.sv
`default_nettype none
// Testbench for seq_frame_transmitter: directed steps plus randomized traffic
// against a slot-level reference model; a second instance runs with CNT_W=2.
module tb_seq_frame_transmitter;

`ifdef SEQ_TX_EXPECT_EN
   localparam bit EXP_EN = 1'b1;
`else
   localparam bit EXP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_data;

   logic       in_ready, out, frame_start, exp_dec;
   logic [7:0] frame_cnt;
   logic       in_ready2, out2, frame_start2, exp_dec2;
   logic [1:0] frame_cnt2;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: current frame word, slot index, pending word, user-frame total
   int         m_slot;
   logic [3:0] m_frame;
   bit         m_held_v;
   logic [3:0] m_held;
   int         m_cnt;

   always #5 clk = ~clk;

   seq_frame_transmitter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out(out), .frame_start(frame_start),
      .exp_dec(exp_dec), .frame_cnt(frame_cnt)
   );

   seq_frame_transmitter #(.FILLER(4'b0000), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready2), .out(out2), .frame_start(frame_start2),
      .exp_dec(exp_dec2), .frame_cnt(frame_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_det(input logic [3:0] w);
      return (w == 4'b0111) || (w == 4'b1001) || (w == 4'b1110);
   endfunction

   task automatic model_reset();
      m_slot   = 0;
      m_frame  = 4'b0000;
      m_held_v = 1'b0;
      m_held   = 4'b0000;
      m_cnt    = 0;
   endtask

   task automatic check_reset_values();
      chk("rst_out", out, 0);
      chk("rst_frame_start", frame_start, 1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_exp_dec", exp_dec, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_frame_cnt_w2", frame_cnt2, 0);
   endtask

   task automatic check_outputs();
      chk("out", out, m_frame[3 - m_slot]);
      chk("frame_start", frame_start, m_slot == 0);
      chk("in_ready", in_ready, !m_held_v);
      chk("exp_dec", exp_dec, EXP_EN && (m_slot == 3) && is_det(m_frame));
      chk("frame_cnt", frame_cnt, m_cnt % 256);
      chk("frame_cnt_w2", frame_cnt2, m_cnt % 4);
      chk("out_w2", out2, m_frame[3 - m_slot]);
   endtask

   // One clock cycle: drive, check mid-cycle, advance the model past the edge.
   task automatic cycle(input logic v, input logic [3:0] d, output bit acc);
      in_valid = v;
      in_data  = d;
      @(negedge clk);
      check_outputs();
      acc = v && !m_held_v;
      @(posedge clk);
      #1;
      if (m_slot == 3) begin
         if (m_held_v) begin
            m_frame  = m_held;
            m_held_v = 1'b0;
            m_cnt++;
         end else if (acc) begin
            m_frame = d;
            m_cnt++;
         end else begin
            m_frame = 4'b0000;
         end
      end else if (acc) begin
         m_held   = d;
         m_held_v = 1'b1;
      end
      m_slot = (m_slot + 1) % 4;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check_reset_values();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, acc);
   endtask

   // Offer each word with in_valid held until the model says it was taken.
   task automatic stream(input logic [3:0] words[$]);
      bit acc;
      int guard;
      foreach (words[i]) begin
         guard = 0;
         acc   = 1'b0;
         while (!acc && guard < 16) begin
            cycle(1'b1, words[i], acc);
            guard++;
         end
         if (!acc) chk("stream_accept_timeout", 0, 1);
      end
   endtask

   initial begin
      bit         acc;
      bit         src_v;
      logic [3:0] src_d;
      logic [3:0] q[$];

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'b0000;
      model_reset();
      @(posedge clk);

      // idle after reset: filler only
      do_reset();
      idle(12);

      // single 0111 offered at cycle 1
      do_reset();
      idle(1);
      cycle(1'b1, 4'b0111, acc);
      idle(10);

      // back-to-back stream
      do_reset();
      q = '{4'b1001, 4'b1110, 4'b0101, 4'b0000};
      stream(q);
      idle(12);

      // bypass on the boundary cycle with an empty buffer
      while (m_slot != 3) cycle(1'b0, 4'b0000, acc);
      cycle(1'b1, 4'b1110, acc);
      idle(8);

      // reset while a word sits in the buffer
      do_reset();
      idle(1);
      cycle(1'b1, 4'b1001, acc);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(8);

      // five user words: narrow counter wraps 1,2,3,0,1
      do_reset();
      q = '{4'b0111, 4'b1001, 4'b1110, 4'b0011, 4'b1111};
      stream(q);
      idle(8);

      // randomized traffic, source holds each word until accepted
      do_reset();
      src_v = 1'b0;
      src_d = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if (!src_v && $urandom_range(0, 2) != 0) begin
            src_v = 1'b1;
            src_d = 4'($urandom);
         end
         cycle(src_v, src_d, acc);
         if (acc) src_v = 1'b0;
      end
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
